// File: rtl/occupancy_scheduler.sv
// Occupancy scheduler: synchronises, debounces and holds N motion zones, then
// time-slices one shared resource among active zones. Define SCHED_STATS_EN to build the grant counter.
module occupancy_scheduler #(
    parameter int N_ZONES      = 4,
    parameter int CLK_FREQ     = 50_000_000,
    parameter int HOLD_SEC     = 120,
    parameter int DEBOUNCE_CYC = 1000,
    parameter int SLOT_CYC     = 5_000_000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_ZONES-1:0]         motion,
    input  logic                       resource_ready,
    output logic                       grant_valid,
    output logic [$clog2(N_ZONES)-1:0] grant_id,
    output logic [N_ZONES-1:0]         grant,
    output logic [N_ZONES-1:0]         zone_active,
    output logic                       active_any,
    output logic [15:0]                grant_count
);

    localparam int ID_W = $clog2(N_ZONES);
    localparam int DW   = $clog2(DEBOUNCE_CYC);
    localparam int SW   = $clog2(SLOT_CYC);
    localparam logic [63:0] HOLD_CYC = 64'(CLK_FREQ) * 64'(HOLD_SEC);
    localparam int TW   = $clog2(HOLD_CYC + 64'd1);

    localparam logic [DW-1:0]      DEB_LAST  = DW'(DEBOUNCE_CYC - 1);
    localparam logic [SW-1:0]      SLOT_LAST = SW'(SLOT_CYC - 1);
    localparam logic [TW-1:0]      HOLD_LOAD = TW'(HOLD_CYC);
    localparam logic [N_ZONES-1:0] ONE_HOT0  = {{(N_ZONES-1){1'b0}}, 1'b1};
    localparam logic [ID_W-1:0]    LAST_ID   = ID_W'(N_ZONES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVE   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    logic [N_ZONES-1:0] sync1_r;
    logic [N_ZONES-1:0] sync2_r;
    logic [N_ZONES-1:0] deb_r;
    logic [DW-1:0]      deb_cnt_r [N_ZONES];
    logic [TW-1:0]      hold_r [N_ZONES];
    logic [TW-1:0]      hold_nxt_s [N_ZONES];
    logic [N_ZONES-1:0] zone_active_r;
    logic [N_ZONES-1:0] active_nxt_s;
    logic               active_any_r;

    state_t             state_r;
    logic [ID_W-1:0]    cur_id_r;
    logic [ID_W-1:0]    rr_ptr_r;
    logic [SW-1:0]      slot_cnt_r;
    logic               grant_valid_r;
    logic [ID_W-1:0]    grant_id_r;
    logic [N_ZONES-1:0] grant_r;

    logic               pick_found_s;
    logic [ID_W-1:0]    pick_id_s;
    int                 pick_idx_s;
    logic [ID_W-1:0]    next_ptr_s;

    // Two-flop synchroniser for the raw sensor levels
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= {N_ZONES{1'b0}};
            sync2_r <= {N_ZONES{1'b0}};
        end else begin
            sync1_r <= motion;
            sync2_r <= sync1_r;
        end
    end

    // Debounce: deb flips only after DEBOUNCE_CYC consecutive differing cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_r <= {N_ZONES{1'b0}};
            for (int i = 0; i < N_ZONES; i++) begin
                deb_cnt_r[i] <= {DW{1'b0}};
            end
        end else begin
            for (int i = 0; i < N_ZONES; i++) begin
                if (sync2_r[i] != deb_r[i]) begin
                    if (deb_cnt_r[i] == DEB_LAST) begin
                        deb_r[i]     <= ~deb_r[i];
                        deb_cnt_r[i] <= {DW{1'b0}};
                    end else begin
                        deb_cnt_r[i] <= deb_cnt_r[i] + DW'(1);
                    end
                end else begin
                    deb_cnt_r[i] <= {DW{1'b0}};
                end
            end
        end
    end

    // Hold timer next state: reload while motion, count down to release
    always_comb begin
        for (int i = 0; i < N_ZONES; i++) begin
            hold_nxt_s[i]   = hold_r[i];
            active_nxt_s[i] = zone_active_r[i];
            if (deb_r[i]) begin
                hold_nxt_s[i]   = HOLD_LOAD;
                active_nxt_s[i] = 1'b1;
            end else if (zone_active_r[i]) begin
                if (hold_r[i] == {TW{1'b0}}) begin
                    active_nxt_s[i] = 1'b0;
                end else begin
                    hold_nxt_s[i] = hold_r[i] - TW'(1);
                end
            end else begin
                hold_nxt_s[i] = hold_r[i];
            end
        end
    end

    // Hold timer and occupancy registers; active_any tracks the same edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zone_active_r <= {N_ZONES{1'b0}};
            active_any_r  <= 1'b0;
            for (int i = 0; i < N_ZONES; i++) begin
                hold_r[i] <= {TW{1'b0}};
            end
        end else begin
            zone_active_r <= active_nxt_s;
            active_any_r  <= |active_nxt_s;
            for (int i = 0; i < N_ZONES; i++) begin
                hold_r[i] <= hold_nxt_s[i];
            end
        end
    end

    // Round-robin pick: first active zone at or after rr_ptr, wrapping
    always_comb begin
        pick_found_s = 1'b0;
        pick_id_s    = {ID_W{1'b0}};
        pick_idx_s   = 0;
        for (int k = 0; k < N_ZONES; k++) begin
            pick_idx_s = int'(rr_ptr_r) + k;
            if (pick_idx_s >= N_ZONES) begin
                pick_idx_s = pick_idx_s - N_ZONES;
            end else begin
                pick_idx_s = pick_idx_s + 0;
            end
            if (!pick_found_s && zone_active_r[pick_idx_s]) begin
                pick_found_s = 1'b1;
                pick_id_s    = ID_W'(pick_idx_s);
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Successor of the zone being served, for the next round-robin start
    always_comb begin
        if (cur_id_r == LAST_ID) begin
            next_ptr_s = {ID_W{1'b0}};
        end else begin
            next_ptr_s = cur_id_r + ID_W'(1);
        end
    end

    // Arbiter FSM with registered handshake outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= IDLE;
            cur_id_r      <= {ID_W{1'b0}};
            rr_ptr_r      <= {ID_W{1'b0}};
            slot_cnt_r    <= {SW{1'b0}};
            grant_valid_r <= 1'b0;
            grant_id_r    <= {ID_W{1'b0}};
            grant_r       <= {N_ZONES{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (pick_found_s) begin
                        cur_id_r      <= pick_id_s;
                        grant_id_r    <= pick_id_s;
                        grant_valid_r <= 1'b1;
                        state_r       <= REQ;
                    end
                end
                REQ: begin
                    if (!zone_active_r[cur_id_r]) begin
                        grant_valid_r <= 1'b0;
                        state_r       <= IDLE;
                    end else if (resource_ready) begin
                        slot_cnt_r <= {SW{1'b0}};
                        grant_r    <= ONE_HOT0 << cur_id_r;
                        state_r    <= SERVE;
                    end
                end
                SERVE: begin
                    if (!zone_active_r[cur_id_r] || slot_cnt_r == SLOT_LAST) begin
                        grant_r       <= {N_ZONES{1'b0}};
                        grant_valid_r <= 1'b0;
                        rr_ptr_r      <= next_ptr_s;
                        state_r       <= RELEASE;
                    end else begin
                        slot_cnt_r <= slot_cnt_r + SW'(1);
                    end
                end
                RELEASE: begin
                    state_r <= IDLE;
                end
                default: begin
                    grant_r       <= {N_ZONES{1'b0}};
                    grant_valid_r <= 1'b0;
                    state_r       <= IDLE;
                end
            endcase
        end
    end

`ifdef SCHED_STATS_EN
    logic [15:0] grant_count_r;

    // Saturating count of REQ->SERVE handshakes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_count_r <= 16'h0000;
        end else if (state_r == REQ && zone_active_r[cur_id_r] && resource_ready
                     && grant_count_r != 16'hFFFF) begin
            grant_count_r <= grant_count_r + 16'h0001;
        end
    end

    assign grant_count = grant_count_r;
`else
    assign grant_count = 16'h0000;
`endif

    assign grant_valid = grant_valid_r;
    assign grant_id    = grant_id_r;
    assign grant       = grant_r;
    assign zone_active = zone_active_r;
    assign active_any  = active_any_r;

endmodule

// File: tb/tb_occupancy_scheduler.sv
// Self-checking bench for occupancy_scheduler: debounce vector table plus
// slice scoreboard for arbitration, hold expiry and reset sequences.
module tb_occupancy_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] motion = 4'b0000;
    logic       resource_ready = 1'b0;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic [3:0] grant;
    logic [3:0] zone_active;
    logic       active_any;
    logic [15:0] grant_count;

`ifdef SCHED_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    occupancy_scheduler #(
        .N_ZONES(4), .CLK_FREQ(10), .HOLD_SEC(2), .DEBOUNCE_CYC(4), .SLOT_CYC(8)
    ) dut (
        .clk(clk), .reset(reset), .motion(motion), .resource_ready(resource_ready),
        .grant_valid(grant_valid), .grant_id(grant_id), .grant(grant),
        .zone_active(zone_active), .active_any(active_any), .grant_count(grant_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    // Scoreboard of expected grant slices, relative to the cycle base of a test
    typedef struct {
        int id;
        int t_start;
        int t_end;
    } slice_t;

    slice_t     exp_q[$];
    slice_t     mon_s;
    int         base = 0;
    bit         mon_en = 1'b0;
    logic [3:0] grant_prev = 4'b0000;
    logic [3:0] mon_oh;
    int         cur_start = 0;
    int         cur_id = 0;

    task automatic push_slice(input int id, input int st, input int en);
        slice_t s;
        s.id = id;
        s.t_start = st;
        s.t_end = en;
        exp_q.push_back(s);
    endtask

    // Grant monitor: records slice start, pops the expected slice at its end
    always @(negedge clk) begin
        if (mon_en) begin
            if (grant_prev == 4'b0000 && grant != 4'b0000) begin
                cur_start = cyc - base;
                cur_id = int'(grant_id);
                mon_oh = 4'b0001;
                mon_oh = mon_oh << grant_id;
                chk("grant_onehot", 32'(grant), 32'(mon_oh));
            end else if (grant_prev != 4'b0000 && grant == 4'b0000) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_slice: actual zone %0d start %0d end %0d required none",
                             cur_id, cur_start, cyc - base);
                end else begin
                    mon_s = exp_q.pop_front();
                    chk("slice_id", 32'(cur_id), 32'(mon_s.id));
                    chk("slice_start", 32'(cur_start), 32'(mon_s.t_start));
                    chk("slice_end", 32'(cyc - base), 32'(mon_s.t_end));
                end
            end
        end
        grant_prev = grant;
    end

    task automatic do_reset();
        mon_en = 1'b0;
        exp_q.delete();
        motion = 4'b0000;
        resource_ready = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Runs n cycles; drops motion after edge drop_at, tracks zone z edges, probes one cycle
    task automatic run(input int n, input int drop_at, input int z, input int probe,
                       output int t_rise, output int t_fall,
                       output logic pv, output logic [1:0] pid, output logic [3:0] pg);
        logic prev;
        int   k;
        t_rise = -1;
        t_fall = -1;
        pv = 1'b0;
        pid = 2'd0;
        pg = 4'b0000;
        prev = zone_active[z];
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (cyc - base == drop_at) motion = 4'b0000;
            @(negedge clk);
            k = cyc - base;
            if (!prev && zone_active[z] && t_rise < 0) t_rise = k;
            if (prev && !zone_active[z] && t_fall < 0) t_fall = k;
            prev = zone_active[z];
            if (k == probe) begin
                pv = grant_valid;
                pid = grant_id;
                pg = grant;
            end
        end
    endtask

    typedef struct {
        int         zone;
        int         len;
        logic [3:0] exp_active;
    } vec_t;

    vec_t       vecs[5];
    int         t_rise, t_fall;
    logic       pv;
    logic [1:0] pid;
    logic [3:0] pg;
    logic [3:0] oh;

    initial begin
        // Pulses shorter than DEBOUNCE_CYC are rejected; 4 or more are accepted
        vecs[0] = '{0, 3, 4'b0000};
        vecs[1] = '{0, 4, 4'b0001};
        vecs[2] = '{1, 2, 4'b0000};
        vecs[3] = '{2, 6, 4'b0100};
        vecs[4] = '{3, 4, 4'b1000};

        repeat (2) @(negedge clk);
        chk("reset_grant_valid", 32'(grant_valid), 32'd0);
        chk("reset_grant", 32'(grant), 32'd0);
        chk("reset_zone_active", 32'(zone_active), 32'd0);
        chk("reset_active_any", 32'(active_any), 32'd0);
        chk("reset_grant_count", 32'(grant_count), 32'd0);

        for (int v = 0; v < 5; v++) begin
            do_reset();
            oh = 4'b0001;
            oh = oh << vecs[v].zone;
            motion = oh;
            base = cyc;
            repeat (vecs[v].len) @(posedge clk);
            #1;
            motion = 4'b0000;
            repeat (10) @(negedge clk);
            chk("vec_zone_active", 32'(zone_active), 32'(vecs[v].exp_active));
            chk("vec_active_any", 32'(active_any), 32'(|vecs[v].exp_active));
            chk("vec_grant_valid", 32'(grant_valid), 32'(|vecs[v].exp_active));
            chk("vec_grant", 32'(grant), 32'd0);
            if (vecs[v].exp_active != 4'b0000)
                chk("vec_grant_id", 32'(grant_id), 32'(vecs[v].zone));
        end

        // Zone 1 for 10 cycles: rise at 7, fall 21 after deb falls (edge 16), regrants in between
        do_reset();
        resource_ready = 1'b1;
        motion = 4'b0010;
        base = cyc;
        mon_en = 1'b1;
        push_slice(1, 9, 17);
        push_slice(1, 20, 28);
        push_slice(1, 31, 38);
        run(60, 10, 1, 8, t_rise, t_fall, pv, pid, pg);
        chk("t2_active_rise", 32'(t_rise), 32'd7);
        chk("t2_active_fall", 32'(t_fall), 32'd37);
        chk("t2_req_valid", 32'(pv), 32'd1);
        chk("t2_req_grant", 32'(pg), 32'd0);
        chk("t2_slices_left", 32'(exp_q.size()), 32'd0);

        // Zones 0 and 2 held: alternating 8-cycle slices
        do_reset();
        resource_ready = 1'b1;
        motion = 4'b0101;
        base = cyc;
        mon_en = 1'b1;
        push_slice(0, 9, 17);
        push_slice(2, 20, 28);
        push_slice(0, 31, 39);
        push_slice(2, 42, 50);
        run(52, 0, 0, 19, t_rise, t_fall, pv, pid, pg);
        chk("t3_req_id", 32'(pid), 32'd2);
        chk("t3_slices_left", 32'(exp_q.size()), 32'd0);

        // Zone 3 waits in REQ while ready is low, served the cycle after ready rises
        do_reset();
        motion = 4'b1000;
        base = cyc;
        mon_en = 1'b1;
        run(8, 0, 3, 8, t_rise, t_fall, pv, pid, pg);
        chk("t4_req_valid_start", 32'(pv), 32'd1);
        chk("t4_req_id_start", 32'(pid), 32'd3);
        run(15, 0, 3, 23, t_rise, t_fall, pv, pid, pg);
        chk("t4_req_valid_end", 32'(pv), 32'd1);
        chk("t4_req_id_end", 32'(pid), 32'd3);
        chk("t4_req_grant_end", 32'(pg), 32'd0);
        resource_ready = 1'b1;
        push_slice(3, 24, 32);
        run(11, 0, 3, 24, t_rise, t_fall, pv, pid, pg);
        chk("t4_grant_after_ready", 32'(pg), 32'b1000);
        chk("t4_slices_left", 32'(exp_q.size()), 32'd0);

        // Zone 2 hold expires mid-slice: release the cycle after zone_active falls
        do_reset();
        resource_ready = 1'b1;
        motion = 4'b0100;
        base = cyc;
        mon_en = 1'b1;
        push_slice(2, 9, 17);
        push_slice(2, 20, 28);
        push_slice(2, 31, 33);
        run(45, 5, 2, 33, t_rise, t_fall, pv, pid, pg);
        chk("t5_active_fall", 32'(t_fall), 32'd32);
        chk("t5_release_valid", 32'(pv), 32'd0);
        chk("t5_idle_valid", 32'(grant_valid), 32'd0);
        chk("t5_idle_any", 32'(active_any), 32'd0);
        chk("t5_slices_left", 32'(exp_q.size()), 32'd0);

        // Reset while zone 2 is served; afterwards rr_ptr=0 so zone 1 wins
        do_reset();
        resource_ready = 1'b1;
        motion = 4'b0110;
        base = cyc;
        mon_en = 1'b1;
        push_slice(1, 9, 17);
        run(22, 0, 2, 22, t_rise, t_fall, pv, pid, pg);
        chk("t6_serving_zone2", 32'(pg), 32'b0100);
        chk("t6_count_before", 32'(grant_count), (STATS != 0) ? 32'd2 : 32'd0);
        mon_en = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        chk("t6_async_grant", 32'(grant), 32'd0);
        chk("t6_async_valid", 32'(grant_valid), 32'd0);
        chk("t6_async_id", 32'(grant_id), 32'd0);
        chk("t6_async_active", 32'(zone_active), 32'd0);
        chk("t6_async_count", 32'(grant_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (grant != 4'b0000) break;
            @(negedge clk);
        end
        chk("t6_first_grant", 32'(grant), 32'b0010);
        chk("t6_first_id", 32'(grant_id), 32'd1);
        chk("t6_count_after", 32'(grant_count), (STATS != 0) ? 32'd1 : 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
